sorted_ram_writer: RTL
======================

# sorted_ram_writer

Write-side companion to the binary `searcher`. It accepts 8-bit values one at a time over a valid/ready handshake and inserts each into a 32-entry sorted array using insertion sort, so the array is always ascending and ready for binary search. A registered read port gives the searcher its memory interface. A `busy` flag tells the top level when the array contents are stable.

## Interface

Parameters:
- `WIDTH`, 8, data width in bits.
- `DEPTH`, 32, number of array entries; must be a power of two.
- `AW`, 5, address width; equals log2(`DEPTH`).

Ports (name, direction, width, meaning):
- `clk`, input, 1, the single clock.
- `reset`, input, 1, asynchronous, active-high.
- `clear`, input, 1, synchronous empty request.
- `in_valid`, input, 1, `in_data` holds a value to insert.
- `in_data`, input, `WIDTH`, value to insert.
- `in_ready`, output, 1, the block can accept a value this cycle.
- `busy`, output, 1, an insertion is in progress; array contents are unstable.
- `count`, output, `AW+1`, number of valid entries, 0..`DEPTH`.
- `full`, output, 1, `count == DEPTH`.
- `rd_addr`, input, `AW`, read address from the searcher.
- `rd_data`, output, `WIDTH`, registered value of `mem[rd_addr]`.

## Operation

Storage:
- `mem[0..DEPTH-1]` is a register array.
- Entries 0..`count-1` are kept in non-decreasing order at all times while `busy` is low.

FSM states:
- IDLE
- SHIFT

Internal registers:
- `hold`: the value being inserted, `WIDTH` bits.
- `idx`: the current hole position, `AW+1` bits.

IDLE:
- `in_ready = !full`.
- On `in_valid && in_ready`: latch `hold <= in_data`, set `idx <= count`, and go to SHIFT.

SHIFT, one decision per clock:
- If `idx > 0` and `mem[idx-1] > hold` (unsigned compare): `mem[idx] <= mem[idx-1]`, `idx <= idx-1`. Stay in SHIFT.
- Otherwise: `mem[idx] <= hold`, `count <= count+1`, go to IDLE.

Ordering rules:
- Equal values are not shifted. A new duplicate is placed after the existing equal entries, so insertion is stable.
- `idx` never exceeds `DEPTH-1` in SHIFT, because acceptance requires `!full`.

Outputs:
- `busy` is high exactly when the state is SHIFT.
- `in_ready` is low in SHIFT.

`clear`:
- `clear` has priority over everything else, in either state.
- Next edge: `count <= 0`, state goes to IDLE, and any in-progress insertion is aborted.
- `mem` contents are left unchanged.
- If `in_valid` is high in the same cycle, it is not accepted.

Read port:
- `rd_data <= mem[rd_addr]` on every edge, independent of state.
- Reads at or above `count` return stale contents. After reset that value is 0.

Arithmetic:
- All comparisons are unsigned.
- `count` saturates by construction and never wraps.

## Timing

- Reset (asynchronous): state IDLE, `count = 0`, `full = 0`, `busy = 0`, `in_ready = 1`, `rd_data = 0`, all `mem` entries 0, `hold = 0`, `idx = 0`.
- Accept edge E0: `busy` rises after E0.
- Insertion latency: for k stored entries greater than `hold`, SHIFT lasts k+1 cycles.
  - Shifts happen at edges E1..Ek.
  - The final write and the `count` increment happen at edge E(k+1).
- After E(k+1): `busy` falls and `in_ready` reflects the new `full`.
- Throughput: the worst case is 1 value per `DEPTH+1` cycles (inserting a new minimum into 31 entries); the best case is 1 value per 2 cycles (inserting a new maximum).
- Read latency: `rd_data` is valid 1 cycle after `rd_addr` is presented.
- The searcher must be started only while `busy == 0`.
- Reset asserted mid-insertion returns all state to the reset values immediately.

## Test plan

1. **Reset values.** Reset, then read addresses 0..31 -> `count=0`, `in_ready=1`, `busy=0`, and every `rd_data` is `0x00` one cycle after its address.
2. **Out-of-order inserts.** Insert 0x50, 0x10, 0x30 back-to-back, honoring `in_ready`.
   - Required contents: `mem[0..2] = 0x10, 0x30, 0x50`, `count=3`.
   - Required `busy` widths: 1, 2, then 2 cycles.
3. **Descending fill.** Insert 31 down to 0, 32 values total.
   - Value n waits 31−n+1 SHIFT cycles.
   - Final state: `full=1`, `in_ready=0`, `mem[i]=i`.
   - A 33rd `in_valid` is never accepted and `count` stays 32.
4. **Duplicates.** Insert 0x20, 0x20, 0x05, 0x20 -> contents 0x05, 0x20, 0x20, 0x20.
   - The last insert has `busy` for exactly 1 cycle, with zero shifts.
5. **Clear.**
   - Assert `clear` during the 3rd SHIFT cycle of inserting 0x00 into [1..8] -> next cycle `count=0`, `busy=0`, `in_ready=1`.
   - Then insert 0x7F -> `mem[0]=0x7F`, `count=1`.
6. **Async reset mid-insertion.** Assert `reset` between clock edges while `busy=1` -> `busy`, `count`, and `rd_data` go to 0 before the next edge.
   - After release, insertion works normally.

Source files
------------

// File: rtl/sorted_ram_writer.sv
// Insertion-sort RAM writer: keeps a register array in ascending order so a
// binary searcher can read it through a registered read port.
module sorted_ram_writer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic [AW:0]      count,
    output logic             full,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_COUNT = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE        = (AW+1)'(1);

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] hold;
    logic [AW:0]      idx;
    logic [AW-1:0]    hole;
    logic [AW-1:0]    below;
    logic             move;

    // idx stays below DEPTH while shifting, so its low bits address the hole
    assign hole  = idx[AW-1:0];
    assign below = hole - AW'(1);
    assign move  = (idx != '0) && (mem[below] > hold);
    assign full  = (count == FULL_COUNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            count    <= '0;
            hold     <= '0;
            idx      <= '0;
            rd_data  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rd_data <= mem[rd_addr];
            if (clear) begin
                state    <= IDLE;
                busy     <= 1'b0;
                in_ready <= 1'b1;
                count    <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (in_valid && in_ready) begin
                            hold     <= in_data;
                            idx      <= count;
                            state    <= SHIFT;
                            busy     <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        if (move) begin
                            mem[hole] <= mem[below];
                            idx       <= {1'b0, below};
                        end else begin
                            // equal entries stop the walk, keeping duplicates stable
                            mem[hole] <= hold;
                            count     <= count + ONE;
                            state     <= IDLE;
                            busy      <= 1'b0;
                            in_ready  <= (count != LAST_COUNT);
                        end
                    end
                endcase
            end
        end
    end

endmodule
